// File: rtl/aib_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : aib_tx_arbiter
// Brief   : 4-way round-robin / fixed-priority burst arbiter with a one-entry
//           output register feeding the AIB adapter TX bus.
//           Optional macro AIB_TX_ARB_STATS_EN adds per-requester beat counters.
// Rev     : 1.0  initial release
// ============================================================================
module aib_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int REQ_DATA_W = 70
) (
  input  logic                          i_bus_clk,
  input  logic                          i_rst,
  input  logic                          c_arb_mode,
  input  logic [3:0]                    c_burst_len,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ*REQ_DATA_W-1:0] i_req_data,
`ifdef AIB_TX_ARB_STATS_EN
  input  logic                          i_stats_clr,
  output logic [NUM_REQ*16-1:0]         o_grant_cnt,
`endif
  output logic                          o_tx_valid,
  input  logic                          i_tx_ready,
  output logic [REQ_DATA_W+1:0]         o_tx_data
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [1:0]            r_owner;
  logic [1:0]            w_owner_nxt;
  logic [3:0]            r_beat_cnt;
  logic [3:0]            w_beat_cnt_nxt;
  logic [1:0]            r_rr_ptr;
  logic [1:0]            w_rr_ptr_nxt;
  logic                  r_tx_valid;
  logic [REQ_DATA_W+1:0] r_tx_data;

  logic                  w_load_en;
  logic [3:0]            w_eff_len;
  logic                  w_any_valid;
  logic                  w_last_beat;
  logic [1:0]            w_winner;
  logic [1:0]            w_idx;
  logic                  w_found;
  logic                  w_grant;
  logic [1:0]            w_grant_idx;
  logic [NUM_REQ-1:0]    w_ready;
  logic [REQ_DATA_W-1:0] w_sel_data;

  assign w_load_en   = !r_tx_valid || i_tx_ready;
  assign w_eff_len   = (c_burst_len == 4'd0) ? 4'd1 : c_burst_len;
  assign w_any_valid = |i_req_valid;
  // Widened compare: a burst length lowered mid-burst still ends on this beat
  assign w_last_beat = ({1'b0, r_beat_cnt} + 5'd1) >= {1'b0, w_eff_len};

  always_comb begin
    w_winner = 2'd0;
    w_found  = 1'b0;
    w_idx    = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = c_arb_mode ? 2'(i) : r_rr_ptr + 2'(i);
      if (!w_found && i_req_valid[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_bus_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= 2'd0;
      r_beat_cnt <= 4'd0;
      r_rr_ptr   <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_beat_cnt_nxt = r_beat_cnt;
    w_rr_ptr_nxt   = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_owner_nxt    = w_winner;
          w_beat_cnt_nxt = 4'd1;
          if (w_eff_len == 4'd1) begin
            w_rr_ptr_nxt = w_winner + 2'd1;
          end else begin
            w_state_nxt = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        // Back-pressure freezes the burst, including a dropped owner valid
        if (w_load_en) begin
          if (i_req_valid[r_owner]) begin
            w_beat_cnt_nxt = r_beat_cnt + 4'd1;
            if (w_last_beat) begin
              w_state_nxt  = ST_IDLE;
              w_rr_ptr_nxt = r_owner + 2'd1;
            end
          end else begin
            w_state_nxt  = ST_IDLE;
            w_rr_ptr_nxt = r_owner + 2'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_grant     = 1'b0;
    w_grant_idx = r_owner;
    w_ready     = '0;
    if (!i_rst && w_load_en) begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_valid) begin
            w_grant     = 1'b1;
            w_grant_idx = w_winner;
          end
        end
        ST_BURST: begin
          if (i_req_valid[r_owner]) begin
            w_grant     = 1'b1;
            w_grant_idx = r_owner;
          end
        end
        default: w_grant = 1'b0;
      endcase
    end
    if (w_grant) begin
      w_ready[w_grant_idx] = 1'b1;
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant_idx == 2'(k)) begin
        w_sel_data = i_req_data[k*REQ_DATA_W +: REQ_DATA_W];
      end
    end
  end

  always_ff @(posedge i_bus_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else if (w_load_en) begin
      r_tx_valid <= w_grant;
      if (w_grant) begin
        r_tx_data <= {w_grant_idx, w_sel_data};
      end
    end
  end

  assign o_req_ready = w_ready;
  assign o_tx_valid  = r_tx_valid;
  assign o_tx_data   = r_tx_data;

`ifdef AIB_TX_ARB_STATS_EN
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_stats
    logic [15:0] r_cnt;
    always_ff @(posedge i_bus_clk or posedge i_rst) begin
      if (i_rst) begin
        r_cnt <= 16'd0;
      end else if (i_stats_clr) begin
        r_cnt <= 16'd0;
      end else if (w_ready[k] && i_req_valid[k] && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
    assign o_grant_cnt[k*16 +: 16] = r_cnt;
  end
`endif

endmodule
`default_nettype wire

// File: doc/aib_tx_arbiter.md
AIB_TX_ARBITER -- requirements
Module: aib_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (fixed at 4 in this revision).
REQ-002 SHALL have parameter REQ_DATA_W, default 70, requester payload width; output word is {2-bit source id, payload} = 72 bits.
REQ-003 SHALL have ports: i_bus_clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have ports: i_rst  in  1  reset, asynchronous assert, active-high.
REQ-005 SHALL have ports: c_arb_mode  in  1  0 = round-robin, 1 = fixed priority (req0 highest).
REQ-006 SHALL have ports: c_burst_len  in  4  max consecutive beats per grant; 0 treated as 1.
REQ-007 SHALL have ports: i_req_valid  in  4  per-requester valid.
REQ-008 SHALL have ports: o_req_ready  out  4  per-requester ready.
REQ-009 SHALL have ports: i_req_data  in  4x70 flattened, requester k at [70k+69:70k].
REQ-010 SHALL have ports: o_tx_valid  out  1, i_tx_ready  in  1, o_tx_data  out  72; these feed the adapter TX bus.

Function
REQ-011 SHALL hold a one-entry output register; load_en = !o_tx_valid | i_tx_ready.
REQ-012 SHALL transfer a requester beat only when load_en and that requester's valid and ready are both high; accepted beat appears on o_tx_data next cycle (latency 1) as {k[1:0], payload}.
REQ-013 SHALL clear o_tx_valid on a cycle with i_tx_ready high and no beat transferred.
REQ-014 SHALL assert at most one o_req_ready bit per cycle, and only when load_en.
REQ-015 SHALL implement FSM IDLE/BURST; register owner (2 bits), beat_cnt (4 bits), rr_ptr (2 bits).
REQ-016 IDLE: if load_en and any valid, winner = first valid from rr_ptr upward modulo 4 (mode 0) or lowest index (mode 1); winner gets ready, beat_cnt <= 1, owner <= winner; go BURST unless effective burst length is 1.
REQ-017 IDLE with no valid or !load_en: no ready, stay IDLE.
REQ-018 BURST: only owner may receive ready; each transfer increments beat_cnt; when beat_cnt reaches effective burst length, go IDLE.
REQ-019 BURST with owner valid low: no ready that cycle, go IDLE next cycle (one bubble).
REQ-020 On every BURST-to-IDLE or IDLE single-beat grant, rr_ptr <= owner+1 modulo 4 (wraps 3 -> 0).
REQ-021 SHALL compare c_burst_len live; if lowered below beat_cnt mid-burst, end burst after current beat.
REQ-022 Back-pressure (i_tx_ready low, o_tx_valid high) SHALL hold o_tx_data stable and FSM state/counters unchanged.

Reset
REQ-023 On i_rst: o_tx_valid 0, o_tx_data 0, o_req_ready 0, FSM IDLE, owner 0, beat_cnt 0, rr_ptr 0.
REQ-024 Reset mid-burst SHALL drop any held output word; the first grant after reset follows REQ-016 from rr_ptr 0.

Configuration
REQ-025 Macro AIB_TX_ARB_STATS_EN SHALL add ports i_stats_clr (in, 1) and o_grant_cnt (out, 4x16), per-requester accepted-beat counters, saturating at 0xFFFF, reset to 0, synchronous clear by i_stats_clr (clear wins over same-cycle increment).
REQ-026 Without AIB_TX_ARB_STATS_EN those ports and counters SHALL not exist; arbitration behaviour identical.

Verification
REQ-027 Mode 0, burst_len 1, all four valid, tx_ready 1 -> output ids 0,1,2,3,0,... one beat per cycle.
REQ-028 Mode 0, burst_len 3, req1 and req2 always valid -> ids 1,1,1,2,2,2,1,...
REQ-029 Mode 1, burst_len 1, req0 and req3 always valid -> only id 0 emitted; req3 starves.
REQ-030 tx_ready held low 5 cycles with o_tx_valid high -> o_tx_data unchanged, no o_req_ready asserted.
REQ-031 burst_len 4, owner req2 drops valid after 2 beats -> one idle cycle, then next grant starts at req3.
REQ-032 With AIB_TX_ARB_STATS_EN, 70000 beats from req0 -> o_grant_cnt[15:0] = 0xFFFF; i_stats_clr pulse -> 0.
